moving_window_integrator: RTL



---
 rtl/pan_tompkins_pkg.sv | 18 +
 rtl/mwi_history_buf.sv | 35 +++
 rtl/moving_window_integrator.sv | 79 +++++++
 3 files changed

// File: rtl/pan_tompkins_pkg.sv
// Shared constants for the Pan-Tompkins QRS detection pipeline stages.
package pan_tompkins_pkg;

  // Default sample width used across the pipeline.
  localparam int unsigned PT_DATA_WIDTH = 16;

  // Default moving-window-integrator window: 2^5 = 32 samples (~160 ms at FS_HZ).
  localparam int unsigned MWI_WIN_LOG2 = 5;

  // ECG sample rate shared by all stages.
  localparam int unsigned FS_HZ = 200;

  // Window length in samples for a given log2 size.
  function automatic int unsigned mwi_window_len(input int unsigned win_log2);
    return 32'd1 << win_log2;
  endfunction

endpackage

// File: rtl/mwi_history_buf.sv
// Circular history of the last N samples for the moving-window integrator.
// Synchronous clear of every entry; combinational read at the write pointer,
// so the parent sees the sample about to be overwritten.
module mwi_history_buf
  import pan_tompkins_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PT_DATA_WIDTH,
  parameter int unsigned WIN_LOG2   = MWI_WIN_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we,
  input  logic [WIN_LOG2-1:0]   wr_ptr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int unsigned N = mwi_window_len(WIN_LOG2);

  logic [DATA_WIDTH-1:0] mem [N];

  // Ring storage: clear all entries on reset, otherwise overwrite the oldest.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[wr_ptr] <= wdata;
    end
  end

  assign rdata = mem[wr_ptr];

endmodule

// File: rtl/moving_window_integrator.sv
// Pan-Tompkins moving-window integration stage.
// Outputs the truncated mean of the last 2^WIN_LOG2 accepted samples, with the
// running sum updated in O(1) from a circular history buffer. Latency 1 cycle.
// Optional build macro MWI_WARMUP_MASK_EN: suppress out_valid until the window
// has been filled; internal state is updated identically either way.
module moving_window_integrator
  import pan_tompkins_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = PT_DATA_WIDTH,
  parameter int unsigned WIN_LOG2   = MWI_WIN_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out,
  output logic                  window_full
);

  // Derived accumulator width; sized so N full-scale samples cannot overflow.
  localparam int unsigned SUM_WIDTH = DATA_WIDTH + WIN_LOG2;
  localparam int unsigned N         = mwi_window_len(WIN_LOG2);
  localparam logic [WIN_LOG2:0] FILL_MAX = (WIN_LOG2 + 1)'(N);

  logic [WIN_LOG2-1:0]   wr_ptr;
  logic [SUM_WIDTH-1:0]  sum;
  logic [SUM_WIDTH-1:0]  sum_nxt;
  logic [WIN_LOG2:0]     fill;
  logic [WIN_LOG2:0]     fill_nxt;
  logic [DATA_WIDTH-1:0] old;
  logic                  valid_nxt;

  mwi_history_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .WIN_LOG2   (WIN_LOG2)
  ) u_hist (
    .clk    (clk),
    .rst    (rst),
    .we     (in_valid),
    .wr_ptr (wr_ptr),
    .wdata  (data),
    .rdata  (old)
  );

  // Next running sum, saturating fill count and result-strobe qualifier.
  always_comb begin
    sum_nxt   = sum + SUM_WIDTH'(data) - SUM_WIDTH'(old);
    fill_nxt  = (fill == FILL_MAX) ? fill : fill + 1'b1;
`ifdef MWI_WARMUP_MASK_EN
    valid_nxt = (fill_nxt == FILL_MAX);
`else
    valid_nxt = 1'b1;
`endif
  end

  // Pointer, accumulator, fill counter and output registers; reset wins over in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      sum       <= '0;
      fill      <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        wr_ptr    <= wr_ptr + 1'b1;
        sum       <= sum_nxt;
        fill      <= fill_nxt;
        out       <= sum_nxt[SUM_WIDTH-1:WIN_LOG2];
        out_valid <= valid_nxt;
      end
    end
  end

  assign window_full = (fill == FILL_MAX);

endmodule
